// File: rtl/score_display_ctrl.sv
// score_display_ctrl
// Shares the digit sprite ROMs among the on-screen score slots. A binary score
// is converted to BCD by a shift-add engine. New digits reach the screen only
// during vertical blanking, so the display never tears. The raster position is
// mapped to slot/ROM addresses. The ROM's one-cycle latency is realigned with a
// registered hit flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for score_load or a queued score
// S_SHIFT | 14 add-3/shift iterations of the BCD conversion
// S_DONE  | result written to pending_bcd, return to idle
module score_display_ctrl #(
  parameter int          NUM_DIGITS    = 4,
  parameter int          ORIGIN_X      = 20,
  parameter int          ORIGIN_Y      = 20,
  parameter int          DIGIT_W       = 25,
  parameter int          DIGIT_H       = 30,
  parameter int          DIGIT_GAP     = 5,
  parameter int          V_BLANK_START = 480,
  parameter logic [11:0] BG_COLOR      = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] score_in,
  input  logic        score_load,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  output logic [3:0]  rom_digit,
  input  logic [11:0] rom_color,
  output logic [11:0] pixel_color,
  output logic        pixel_hit,
  output logic        busy
);

  localparam int BIN_W      = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int SR_W       = BCD_W + BIN_W;
  localparam int SLOT_PITCH = DIGIT_W + DIGIT_GAP;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_adj;
  logic [3:0]         iter_cnt;
  logic [BIN_W-1:0]   queue_val;
  logic               queued;
  logic [BIN_W-1:0]   score_sat;
  logic [BCD_W-1:0]   pending_bcd;
  logic               pending_valid;
  logic [BCD_W-1:0]   committed_bcd;
  logic [NUM_DIGITS-1:0] blank;
  logic               seen_nz;
  logic               y_in;
  logic               hit;
  logic               hit_d1;

  // Slot 0 is the most significant digit of the committed value.
  function automatic logic [3:0] digit_of(input logic [BCD_W-1:0] bcd, input int k);
    return bcd[4*(NUM_DIGITS-1-k) +: 4];
  endfunction

  // Clamp the incoming score to the largest value four digits can show.
  assign score_sat = (score_in > 14'd9999) ? 14'd9999 : score_in;

  // The engine stays busy across a queued back-to-back conversion, including
  // the single idle cycle between them.
  assign busy = (state != S_IDLE) | queued;

  // Add-3 correction on every BCD nibble of 5 or more before each shift.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  // Conversion sequencer, iteration down-counter and load queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      iter_cnt  <= '0;
      queue_val <= '0;
      queued    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (score_load) begin
            sr       <= {{BCD_W{1'b0}}, score_sat};
            queued   <= 1'b0;
            iter_cnt <= 4'd13;
            state    <= S_SHIFT;
          end else if (queued) begin
            sr       <= {{BCD_W{1'b0}}, queue_val};
            queued   <= 1'b0;
            iter_cnt <= 4'd13;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr <= {sr_adj[SR_W-2:0], 1'b0};
          if (iter_cnt == 4'd0)
            state <= S_DONE;
          else
            iter_cnt <= iter_cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Loads arriving mid-conversion are parked; the latest one wins.
      if (score_load && state != S_IDLE) begin
        queue_val <= score_sat;
        queued    <= 1'b1;
      end
    end
  end

  // Hold finished results until blanking, then commit them to the screen.
  // A commit in the DONE cycle takes the old pending value; the new result
  // stays pending for the next blanking cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_bcd   <= '0;
      pending_valid <= 1'b0;
      committed_bcd <= '0;
    end else begin
      if (y >= 10'(V_BLANK_START) && pending_valid) begin
        committed_bcd <= pending_bcd;
        pending_valid <= 1'b0;
      end
      if (state == S_DONE) begin
        pending_bcd   <= sr[SR_W-1 -: BCD_W];
        pending_valid <= 1'b1;
      end
    end
  end

  // Leading-zero blanking; the last slot always shows a digit.
  always_comb begin
    seen_nz = 1'b0;
    blank   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_of(committed_bcd, k) != 4'd0)
        seen_nz = 1'b1;
      blank[k] = !seen_nz && (k != NUM_DIGITS-1);
    end
  end

  // Raster to slot/ROM address decode. Addresses are driven for any in-box
  // pixel; blanking only suppresses the hit.
  always_comb begin
    rom_row   = '0;
    rom_col   = '0;
    rom_digit = '0;
    hit       = 1'b0;
    y_in      = (y >= 10'(ORIGIN_Y)) && (y < 10'(ORIGIN_Y + DIGIT_H));
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (y_in && (int'(x) >= ORIGIN_X + k*SLOT_PITCH) &&
          (int'(x) <  ORIGIN_X + k*SLOT_PITCH + DIGIT_W)) begin
        rom_row   = 5'(int'(y) - ORIGIN_Y);
        rom_col   = 5'(int'(x) - (ORIGIN_X + k*SLOT_PITCH));
        rom_digit = digit_of(committed_bcd, k);
        hit       = !blank[k];
      end
    end
  end

  // Delay the hit to line up with ROM data, then register the pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d1      <= 1'b0;
      pixel_hit   <= 1'b0;
      pixel_color <= 12'h000;
    end else begin
      hit_d1      <= hit;
      pixel_hit   <= hit_d1;
      pixel_color <= hit_d1 ? rom_color : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: reset, conversion timing, blanking
// commit, saturation, queueing, address/latency and mid-conversion reset.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] score_in;
  logic        score_load;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic [3:0]  rom_digit;
  logic [11:0] rom_color;
  logic [11:0] pixel_color;
  logic        pixel_hit;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  score_display_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .score_in   (score_in),
    .score_load (score_load),
    .x          (x),
    .y          (y),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_digit  (rom_digit),
    .rom_color  (rom_color),
    .pixel_color(pixel_color),
    .pixel_hit  (pixel_hit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse score_load for one cycle; returns at the negedge of the cycle after.
  task automatic load_score(input int val);
    @(negedge clk);
    score_in   = 14'(val);
    score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
  endtask

  // Count consecutive busy cycles starting now, bounded.
  task automatic count_busy(output int cnt);
    int guard;
    cnt   = 0;
    guard = 0;
    while (busy && guard < 100) begin
      cnt++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) check_val("busy_timeout", 1, 0);
  endtask

  // One raster line inside vertical blanking.
  task automatic blank_line;
    @(negedge clk);
    y = 10'd480;
    @(negedge clk);
    y = 10'd100;
  endtask

  // Combinational digit select at the second column of slot k.
  task automatic check_digit(input int k, input int exp);
    x = 10'(20 + 30*k + 1);
    y = 10'd21;
    #1;
    check_val($sformatf("digit%0d", k), 32'(rom_digit), 32'(exp));
  endtask

  // Present (px, py), feed ROM data one cycle later, check the registered pixel.
  task automatic check_pix(input string tag, input int px, input int py,
                           input logic [11:0] col, input logic exp_hit,
                           input logic [11:0] exp_col);
    @(negedge clk);
    x         = 10'(px);
    y         = 10'(py);
    rom_color = 12'h000;
    @(negedge clk);
    rom_color = col;
    @(negedge clk);
    check_val({tag, "_hit"}, 32'(pixel_hit), 32'(exp_hit));
    check_val({tag, "_col"}, 32'(pixel_color), 32'(exp_col));
  endtask

  initial begin
    int bcnt;
    reset_n    = 1'b0;
    score_in   = '0;
    score_load = 1'b0;
    x          = 10'd0;
    y          = 10'd100;
    rom_color  = 12'hFFF;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_color", 32'(pixel_color), 32'h000);
    check_val("rst_hit",   32'(pixel_hit),   0);
    check_val("rst_busy",  32'(busy),        0);
    reset_n = 1'b1;

    // Idle display: only the last slot shows "0"
    check_digit(3, 0);
    check_pix("idle_s0", 22, 25, 12'hABC, 1'b0, 12'h000);
    check_pix("idle_s2", 82, 25, 12'hABC, 1'b0, 12'h000);
    check_pix("idle_s3", 113, 25, 12'hABC, 1'b1, 12'hABC);

    // Load 1234 outside blanking
    y = 10'd100;
    load_score(1234);
    count_busy(bcnt);
    check_val("busy_len_1234", 32'(bcnt), 15);
    repeat (5) @(negedge clk);
    check_digit(0, 0);
    check_digit(3, 0);
    blank_line();
    check_digit(0, 1);
    check_digit(1, 2);
    check_digit(2, 3);
    check_digit(3, 4);

    // Address decode and pixel latency
    @(negedge clk);
    x = 10'd57;
    y = 10'd32;
    #1;
    check_val("addr_row",   32'(rom_row),   12);
    check_val("addr_col",   32'(rom_col),   7);
    check_val("addr_digit", 32'(rom_digit), 2);
    check_pix("lat", 57, 32, 12'h0F0, 1'b1, 12'h0F0);
    @(negedge clk);
    x = 10'd45;
    y = 10'd32;
    #1;
    check_val("gap_col",   32'(rom_col),   0);
    check_val("gap_digit", 32'(rom_digit), 0);
    check_pix("gap", 45, 32, 12'h0F0, 1'b0, 12'h000);

    // Saturation
    y = 10'd100;
    load_score(12000);
    count_busy(bcnt);
    check_val("busy_len_sat", 32'(bcnt), 15);
    blank_line();
    for (int k = 0; k < 4; k++) check_digit(k, 9);

    // Queueing: 56 arrives three cycles after 1234
    y = 10'd100;
    @(negedge clk);
    score_in   = 14'd1234;
    score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
    begin
      int c;
      c    = 1;
      bcnt = 0;
      while (busy && c < 100) begin
        bcnt++;
        if (c == 3) begin
          score_in   = 14'd56;
          score_load = 1'b1;
        end else begin
          score_load = 1'b0;
        end
        @(negedge clk);
        c++;
      end
      score_load = 1'b0;
      if (c >= 100) check_val("queue_timeout", 1, 0);
    end
    check_val("busy_len_queue", 32'(bcnt), 31);
    blank_line();
    check_digit(0, 0);
    check_digit(1, 0);
    check_digit(2, 5);
    check_digit(3, 6);
    check_pix("q_s1", 52, 25, 12'h321, 1'b0, 12'h000);
    check_pix("q_s2", 82, 25, 12'h321, 1'b1, 12'h321);

    // Reset in the middle of a conversion
    @(negedge clk);
    x          = 10'd113;
    y          = 10'd25;
    rom_color  = 12'h123;
    score_in   = 14'd1234;
    score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
    repeat (6) @(negedge clk);
    check_val("mid_busy",  32'(busy),      1);
    check_val("mid_hit",   32'(pixel_hit), 1);
    reset_n = 1'b0;
    #1;
    check_val("arst_busy",  32'(busy),        0);
    check_val("arst_hit",   32'(pixel_hit),   0);
    check_val("arst_color", 32'(pixel_color), 32'h000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("post_busy", 32'(busy), 0);
    blank_line();
    check_digit(3, 0);
    check_pix("post_s2", 82, 25, 12'h456, 1'b0, 12'h000);
    check_pix("post_s3", 113, 25, 12'h456, 1'b1, 12'h456);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Sequencer and address generator that shares the 25×30 digit sprite ROMs among the score digits on screen. It converts a binary score to BCD with a multi-cycle shift-add engine and commits new digits only during vertical blanking, so the display never tears. Each cycle it maps the raster position (x, y) to a digit slot, ROM row/col and digit select, then realigns the ROM's one-cycle-latency colour with a hit pipeline. It sits between the VGA sync generator and the pixel mux.

## Interface

- NUM_DIGITS, 4, digit slots; slot 0 is the most significant.
- ORIGIN_X, 20, x of the left edge of slot 0.
- ORIGIN_Y, 20, y of the top edge of all slots.
- DIGIT_W, 25, sprite width (ROM col range 0..24).
- DIGIT_H, 30, sprite height (ROM row range 0..29).
- DIGIT_GAP, 5, blank pixels between slots.
- V_BLANK_START, 480, first y line of vertical blanking.
- BG_COLOR, 12'h000, colour for blanked slots.
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- score_in  in  14  binary score.
- score_load  in  1  one-cycle pulse that samples score_in.
- x  in  10  current raster column.
- y  in  10  current raster line.
- rom_row  out  5  ROM row address (combinational).
- rom_col  out  5  ROM column address (combinational).
- rom_digit  out  4  digit ROM select, 0..9 (combinational).
- rom_color  in  12  muxed ROM data, valid one cycle after the address.
- pixel_color  out  12  registered output colour.
- pixel_hit  out  1  registered flag: pixel_color belongs to the score.
- busy  out  1  conversion in progress.

## Operation

- Saturation: a sampled score above 9999 is replaced with 9999 before conversion.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE, on score_load or when the queued flag is set: load the shift register and go to SHIFT.
  - SHIFT: 14 iterations. Each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole register left one bit.
  - DONE: write the BCD result to pending_bcd, set pending_valid, go to IDLE.
- Queueing: score_load while busy, or in the same cycle as DONE, stores score_in in the queue register and sets the queued flag.
  - A later load overwrites the queue (latest value wins).
  - The queued value starts conversion in the cycle after the FSM returns to IDLE.
- Commit: on any cycle with y ≥ V_BLANK_START and pending_valid = 1:
  - committed_bcd ← pending_bcd;
  - pending_valid is cleared.
  - If a new DONE occurs before the commit, it overwrites pending_bcd.
- Slot decode:
  - Slot k spans x in [ORIGIN_X + k·(DIGIT_W+DIGIT_GAP), that value + DIGIT_W) and y in [ORIGIN_Y, ORIGIN_Y + DIGIT_H).
  - On a hit: rom_row = y − ORIGIN_Y, rom_col = x − slot start, rom_digit = committed digit k.
  - Gaps and off-box pixels: hit = 0 and rom_row, rom_col, rom_digit are driven to 0.
- Leading-zero blanking: slots whose committed digit is 0 and that lie left of the first non-zero digit are blanked. Slot NUM_DIGITS−1 is never blanked. A blanked slot gives pixel_hit = 0 and pixel_color = BG_COLOR.
- Output stage: pixel_color = hit_d1 ? rom_color : BG_COLOR; pixel_hit = hit_d1 (blanking already folded into hit).

## Timing

- Reset values:
  - pixel_color = 12'h000, pixel_hit = 0, busy = 0;
  - FSM = IDLE, committed_bcd and pending_bcd = 0, pending_valid = 0, queued flag = 0, hit pipeline = 0.
  - The screen therefore shows "0" in the last slot only.
- Conversion, with score_load at cycle N and busy = 0:
  - busy = 1 during cycles N+1..N+15 (SHIFT N+1..N+14, DONE N+15);
  - pending_valid = 1 from N+16; busy = 0 at N+16.
- Pixel path latency: x, y at cycle N → ROM address at N → rom_color at N+1 → pixel_color and pixel_hit registered at the end of N+1, visible at N+2.
- Reset asserted mid-conversion: everything returns to reset values immediately; the queued and in-flight scores are lost.
- A commit on the same cycle as DONE uses the previous pending_bcd. The new result commits in the next blanking cycle.

## Test plan

- Reset and idle: raster a full frame. Slots 0–2 give pixel_hit = 0; slot 3 has rom_digit = 0; pixel_color = 12'h000 during reset.
- Load 1234 at y = 100:
  - busy stays high for 15 cycles.
  - committed digits stay 0 until the first cycle at y = 480, then read 1, 2, 3, 4 in slots 0–3.
- Saturation: load 12000 → digits 9, 9, 9, 9 after blanking.
- Queueing: load 1234, then 56 three cycles later.
  - busy stays high across both conversions (31 cycles) and 1234 is never committed if blanking occurs after the second DONE.
  - Final display is blank, blank, 5, 6.
- Address and latency, with defaults:
  - x = 57, y = 32 → rom_row = 12, rom_col = 7, rom_digit = slot-1 digit.
  - rom_color = 12'h0F0 on the next cycle → pixel_color = 12'h0F0 and pixel_hit = 1 two cycles after x, y.
  - x = 45 (gap) → pixel_hit = 0.
- Assert reset_n low at SHIFT iteration 7: busy = 0 and pixel_hit = 0 immediately. After release, the display shows "0".
